increment_scheduler: RTL
========================

INCREMENT_SCHEDULER -- requirements
Module: increment_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  FIFO can accept a command.
REQ-006 SHALL have port cmd_value  input  4  increment to emit.
REQ-007 SHALL have port cmd_repeat  input  8  number of cycles to emit cmd_value.
REQ-008 SHALL have port add_value  output  4  registered increment fed to the downstream accumulating counter.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port cmd_done  output  1  one-cycle pulse at the final emit cycle of each command.
REQ-011 SHALL have port fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-012 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready = (fifo_level != DEPTH), with no bypass when full and popping.
REQ-013 SHALL hold {cmd_value, cmd_repeat} in FIFO order, with pointers wrapping modulo DEPTH.
REQ-014 SHALL implement FSM states IDLE and RUN; IDLE->RUN when FIFO non-empty, RUN->IDLE at the final emit cycle if FIFO empty, RUN->RUN (next command popped) at the final emit cycle if FIFO non-empty.
REQ-015 SHALL pop the head at the edge that enters RUN or chains to the next command, loading add_value = value and remaining = repeat-1 at that edge.
REQ-016 SHALL drive add_value = cmd_value for exactly cmd_repeat consecutive cycles per command, with zero gap cycles between chained commands.
REQ-017 SHALL, for cmd_repeat = 0, pop and discard the command with no emit cycle, pulse cmd_done for one cycle, and keep add_value = 0 during that cycle.
REQ-018 SHALL drive add_value = 0 in every cycle spent in IDLE.
REQ-019 SHALL set latency so that a command accepted at edge E0 into an empty, idle block first appears on add_value after edge E1.
REQ-020 SHALL update fifo_level by +1 on push only, -1 on pop only, and leave it unchanged on a simultaneous push and pop.
REQ-021 SHALL assert cmd_done in the cycle in which the final add_value of a command is presented.
REQ-022 SHALL keep all outputs registered except cmd_ready, which is decoded from fifo_level.

Reset
REQ-023 SHALL, on reset assertion, immediately force add_value=0, busy=0, cmd_done=0, fifo_level=0, FSM=IDLE and clear both pointers, without waiting for a clock edge.
REQ-024 SHALL discard an in-progress command and all queued commands on mid-operation reset, and drive cmd_ready=1 while reset is high.
REQ-025 SHALL accept nothing at the first rising edge while reset is high.

Structure
REQ-026 SHALL place the state enum (IDLE, RUN), the VALUE_W=4 and REPEAT_W=8 constants and the command struct in the shared package inc_sched_pkg.
REQ-027 SHALL implement the FIFO as sub-module cmd_fifo (push/pop/full/empty/level), with the FSM and repeat counter in the top.

Verification
REQ-028 SHALL cover: reset, then push (3,4) -> add_value 3 for 4 cycles starting 1 cycle after accept, cmd_done on the 4th cycle, downstream count = 12.
REQ-029 SHALL cover: push (3,4) and (5,4) back-to-back -> 8 contiguous cycles (3,3,3,3,5,5,5,5), two cmd_done pulses, count = 32.
REQ-030 SHALL cover: push 5 commands (1,10) with DEPTH=4 while the first runs -> cmd_ready low exactly when fifo_level=4, no command lost, count = 50.
REQ-031 SHALL cover: push (7,0) followed by (2,3) -> one cmd_done pulse with add_value=0, then 2 for 3 cycles, count = 6.
REQ-032 SHALL cover: reset asserted mid-run of (5,8) after 3 emits -> add_value=0 immediately, fifo_level=0, busy=0; push (2,3) after release -> count = 6.
REQ-033 SHALL cover: continuous push/pop with FIFO at level 1 for 20 commands -> pointer wrap verified, fifo_level constant, no gaps.

Source files
------------

// File: rtl/inc_sched_pkg.sv
// Shared types and widths for the increment scheduler: FSM states, field widths
// and the queued command record.
package inc_sched_pkg;

    localparam int VALUE_W  = 4;
    localparam int REPEAT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [VALUE_W-1:0]  value;
        logic [REPEAT_W-1:0] rpt;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO for the increment scheduler: power-of-two depth, wrapping pointers,
// occupancy counter; a push is refused whenever full, even on a popping edge.
module cmd_fifo
    import inc_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  cmd_t                     push_cmd,
    input  logic                     pop,
    output cmd_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; validity is tracked by the pointers and level alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/increment_scheduler.sv
// Drains queued {value, repeat} commands into a registered add_value stream for a
// downstream accumulating counter, chaining commands with no gap cycles.
module increment_scheduler
    import inc_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [VALUE_W-1:0]      cmd_value,
    input  logic [REPEAT_W-1:0]     cmd_repeat,
    output logic [VALUE_W-1:0]      add_value,
    output logic                    busy,
    output logic                    cmd_done,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    state_t              state;
    state_t              state_next;
    logic [REPEAT_W-1:0] remaining;
    logic [REPEAT_W-1:0] remaining_next;
    logic [VALUE_W-1:0]  add_next;
    logic                done_next;
    logic                pop;
    logic                last_emit;
    logic                fifo_full;
    logic                fifo_empty;
    cmd_t                head;

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (cmd_valid),
        .push_cmd ('{value: cmd_value, rpt: cmd_repeat}),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign cmd_ready = !fifo_full;
    // A zero-repeat command occupies one RUN cycle with remaining already at zero.
    assign last_emit = (state == RUN) && (remaining == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = RUN;
                    pop        = 1'b1;
                end
            end
            RUN: begin
                if (last_emit) begin
                    pop        = !fifo_empty;
                    state_next = fifo_empty ? IDLE : RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        add_next       = '0;
        remaining_next = remaining;
        done_next      = 1'b0;
        if (pop) begin
            add_next       = (head.rpt == '0) ? '0 : head.value;
            remaining_next = (head.rpt == '0) ? '0 : head.rpt - REPEAT_W'(1);
            done_next      = (head.rpt <= REPEAT_W'(1));
        end else if (state == RUN && !last_emit) begin
            add_next       = add_value;
            remaining_next = remaining - REPEAT_W'(1);
            done_next      = (remaining == REPEAT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            add_value <= '0;
            cmd_done  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            remaining <= remaining_next;
            add_value <= add_next;
            cmd_done  <= done_next;
            busy      <= (state_next == RUN);
        end
    end

endmodule
